// File: rtl/bank_router.sv
// bank_router: decodes each CPU byte lane onto one of NTARGETS banked targets,
// inserts per-target wait states, and returns read data after the longest wait.
module bank_router #(
  parameter int unsigned              ADDRBITS = 15,
  parameter int unsigned              NTARGETS = 2,
  parameter logic [16*NTARGETS-1:0]   BASE     = {16'h2000, 16'h0000},
  parameter logic [4*NTARGETS-1:0]    WAITS    = {4'd0, 4'd2}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDRBITS-1:0]   dread_addr_even,
  input  logic [ADDRBITS-1:0]   dread_addr_odd,
  input  logic                  dread_req,
  input  logic [ADDRBITS-1:0]   dwrite_addr_even,
  input  logic [ADDRBITS-1:0]   dwrite_addr_odd,
  input  logic [7:0]            dwrite_data_even,
  input  logic [7:0]            dwrite_data_odd,
  input  logic                  dwrite_en_even,
  input  logic                  dwrite_en_odd,
  output logic                  ready,
  output logic [7:0]            dread_data_even,
  output logic [7:0]            dread_data_odd,
  output logic                  dread_valid,
  output logic [ADDRBITS-1:0]   t_dread_addr_even,
  output logic [ADDRBITS-1:0]   t_dread_addr_odd,
  output logic [ADDRBITS-1:0]   t_dwrite_addr_even,
  output logic [ADDRBITS-1:0]   t_dwrite_addr_odd,
  output logic [7:0]            t_dwrite_data_even,
  output logic [7:0]            t_dwrite_data_odd,
  output logic [NTARGETS-1:0]   t_dwrite_en_even,
  output logic [NTARGETS-1:0]   t_dwrite_en_odd,
  input  logic [8*NTARGETS-1:0] t_dread_data_even,
  input  logic [8*NTARGETS-1:0] t_dread_data_odd
);

  localparam int unsigned TW = (NTARGETS > 1) ? $clog2(NTARGETS) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state, state_next;
  logic [3:0]      cnt, cnt_next;
  logic            rd_pend, rd_pend_next;
  logic            valid_next;
  logic            accept;
  logic [3:0]      w_max;
  logic [TW-1:0]   tgt_re, tgt_ro, tgt_we, tgt_wo;
  logic [TW-1:0]   rd_tgt_e, rd_tgt_o;
  logic [ADDRBITS-1:0] h_rae, h_rao, h_wae, h_wao;
  logic [7:0]      h_wde, h_wdo;
  logic [7:0]      hold_e, hold_o, mux_e, mux_o;

  // Highest target whose base is at or below the byte address.
  function automatic logic [TW-1:0] decode(input logic [ADDRBITS:0] baddr);
    logic [TW-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < NTARGETS; i++) begin
      if (32'(baddr) >= 32'(BASE[16*i +: 16])) t = TW'(i);
    end
    return t;
  endfunction

  function automatic logic [3:0] wait_of(input logic [TW-1:0] t);
    return WAITS[{t, 2'b00} +: 4];
  endfunction

  assign tgt_re = decode({dread_addr_even, 1'b0});
  assign tgt_ro = decode({dread_addr_odd, 1'b1});
  assign tgt_we = decode({dwrite_addr_even, 1'b0});
  assign tgt_wo = decode({dwrite_addr_odd, 1'b1});

  assign ready  = (state == IDLE);
  assign accept = ready && (dread_req || dwrite_en_even || dwrite_en_odd);

  // Longest wait among all lanes taking part in this access.
  always_comb begin
    w_max = '0;
    if (dread_req) begin
      if (wait_of(tgt_re) > w_max) w_max = wait_of(tgt_re);
      if (wait_of(tgt_ro) > w_max) w_max = wait_of(tgt_ro);
    end
    if (dwrite_en_even && (wait_of(tgt_we) > w_max)) w_max = wait_of(tgt_we);
    if (dwrite_en_odd  && (wait_of(tgt_wo) > w_max)) w_max = wait_of(tgt_wo);
  end

  // Next-state, wait counter and read-completion scheduling.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    rd_pend_next = rd_pend;
    valid_next   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (w_max != '0) begin
            state_next = WAIT;
            cnt_next   = w_max - 4'd1;
          end
          rd_pend_next = dread_req && (w_max != '0);
          valid_next   = dread_req && (w_max == '0);
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next   = IDLE;
          rd_pend_next = 1'b0;
          valid_next   = rd_pend;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM and completion state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rd_pend     <= 1'b0;
      dread_valid <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      rd_pend     <= rd_pend_next;
      dread_valid <= valid_next;
    end
  end

  // Capture the accepted access so the target buses stay stable while waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_rae    <= '0;
      h_rao    <= '0;
      h_wae    <= '0;
      h_wao    <= '0;
      h_wde    <= '0;
      h_wdo    <= '0;
      rd_tgt_e <= '0;
      rd_tgt_o <= '0;
    end else if (accept) begin
      h_rae <= dread_addr_even;
      h_rao <= dread_addr_odd;
      h_wae <= dwrite_addr_even;
      h_wao <= dwrite_addr_odd;
      h_wde <= dwrite_data_even;
      h_wdo <= dwrite_data_odd;
      if (dread_req) begin
        rd_tgt_e <= tgt_re;
        rd_tgt_o <= tgt_ro;
      end
    end
  end

  assign mux_e = t_dread_data_even[{rd_tgt_e, 3'b000} +: 8];
  assign mux_o = t_dread_data_odd[{rd_tgt_o, 3'b000} +: 8];

  // Remember the last returned read data so the outputs hold between pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_e <= '0;
      hold_o <= '0;
    end else if (dread_valid) begin
      hold_e <= mux_e;
      hold_o <= mux_o;
    end
  end

  assign dread_data_even = dread_valid ? mux_e : hold_e;
  assign dread_data_odd  = dread_valid ? mux_o : hold_o;

  assign t_dread_addr_even  = ready ? dread_addr_even  : h_rae;
  assign t_dread_addr_odd   = ready ? dread_addr_odd   : h_rao;
  assign t_dwrite_addr_even = ready ? dwrite_addr_even : h_wae;
  assign t_dwrite_addr_odd  = ready ? dwrite_addr_odd  : h_wao;
  assign t_dwrite_data_even = ready ? dwrite_data_even : h_wde;
  assign t_dwrite_data_odd  = ready ? dwrite_data_odd  : h_wdo;

  // One-hot write strobes, only in the cycle the write is accepted.
  always_comb begin
    t_dwrite_en_even = '0;
    t_dwrite_en_odd  = '0;
    if (accept && dwrite_en_even) t_dwrite_en_even[tgt_we] = 1'b1;
    if (accept && dwrite_en_odd)  t_dwrite_en_odd[tgt_wo]  = 1'b1;
  end

endmodule

// File: tb/tb_bank_router.sv
// Randomized bench for bank_router with a transaction-level reference model.
module tb_bank_router;

  localparam int AB = 15;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AB-1:0] dread_addr_even = '0, dread_addr_odd = '0;
  logic          dread_req = 1'b0;
  logic [AB-1:0] dwrite_addr_even = '0, dwrite_addr_odd = '0;
  logic [7:0]    dwrite_data_even = '0, dwrite_data_odd = '0;
  logic          dwrite_en_even = 1'b0, dwrite_en_odd = 1'b0;
  logic          ready, dread_valid;
  logic [7:0]    dread_data_even, dread_data_odd;
  logic [AB-1:0] t_dread_addr_even, t_dread_addr_odd, t_dwrite_addr_even, t_dwrite_addr_odd;
  logic [7:0]    t_dwrite_data_even, t_dwrite_data_odd;
  logic [1:0]    t_dwrite_en_even, t_dwrite_en_odd;
  logic [15:0]   t_dread_data_even = '0, t_dread_data_odd = '0;

  always #5 clk = ~clk;

  bank_router #(.ADDRBITS(AB), .NTARGETS(2), .BASE({16'h2000, 16'h0000}), .WAITS({4'd0, 4'd2})) dut (
    .clk(clk), .reset_n(reset_n),
    .dread_addr_even(dread_addr_even), .dread_addr_odd(dread_addr_odd), .dread_req(dread_req),
    .dwrite_addr_even(dwrite_addr_even), .dwrite_addr_odd(dwrite_addr_odd),
    .dwrite_data_even(dwrite_data_even), .dwrite_data_odd(dwrite_data_odd),
    .dwrite_en_even(dwrite_en_even), .dwrite_en_odd(dwrite_en_odd),
    .ready(ready), .dread_data_even(dread_data_even), .dread_data_odd(dread_data_odd),
    .dread_valid(dread_valid),
    .t_dread_addr_even(t_dread_addr_even), .t_dread_addr_odd(t_dread_addr_odd),
    .t_dwrite_addr_even(t_dwrite_addr_even), .t_dwrite_addr_odd(t_dwrite_addr_odd),
    .t_dwrite_data_even(t_dwrite_data_even), .t_dwrite_data_odd(t_dwrite_data_odd),
    .t_dwrite_en_even(t_dwrite_en_even), .t_dwrite_en_odd(t_dwrite_en_odd),
    .t_dread_data_even(t_dread_data_even), .t_dread_data_odd(t_dread_data_odd)
  );

  // Reference rules: target 1 from byte 0x2000 up, target 0 has 2 wait states.
  function automatic int tgt_of(input int b);
    return (b >= 'h2000) ? 1 : 0;
  endfunction

  function automatic int waits_of(input int t);
    return (t == 0) ? 2 : 0;
  endfunction

  function automatic logic [7:0] byte_val(input int t, input int b);
    logic [7:0] v;
    v = 8'(b) + 8'(b >> 8) * 8'd3;
    return (t != 0) ? (v ^ 8'hC3) : v;
  endfunction

  // Synchronous target memories: each target answers every address with a known pattern.
  always @(posedge clk) begin
    t_dread_data_even <= {byte_val(1, int'({t_dread_addr_even, 1'b0})), byte_val(0, int'({t_dread_addr_even, 1'b0}))};
    t_dread_data_odd  <= {byte_val(1, int'({t_dread_addr_odd, 1'b1})),  byte_val(0, int'({t_dread_addr_odd, 1'b1}))};
  end

  typedef struct {
    int unsigned cyc;
    logic [15:0] data;
  } rd_t;

  rd_t         q[$];
  int unsigned cyc = 0, busy_until = 0;
  int unsigned n_vec = 0, n_err = 0;
  logic [7:0]  last_e = '0, last_o = '0;
  logic [75:0] held = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive inputs, check outputs at the falling edge, advance the model.
  task automatic step(input logic rq, input logic [AB-1:0] rae, input logic [AB-1:0] rao,
                      input logic we_e, input logic we_o, input logic [AB-1:0] wae,
                      input logic [AB-1:0] wao, input logic [7:0] wde, input logic [7:0] wdo);
    logic        exp_ready, exp_valid, acc;
    logic [75:0] cur, exp_bus;
    logic [1:0]  ewe, ewo;
    int          w, be, bo;
    dread_req = rq; dread_addr_even = rae; dread_addr_odd = rao;
    dwrite_en_even = we_e; dwrite_en_odd = we_o;
    dwrite_addr_even = wae; dwrite_addr_odd = wao;
    dwrite_data_even = wde; dwrite_data_odd = wdo;
    @(negedge clk);
    exp_ready = (cyc >= busy_until);
    exp_valid = (q.size() > 0) && (q[0].cyc == cyc);
    if (exp_valid) begin
      {last_e, last_o} = q[0].data;
      void'(q.pop_front());
    end
    check("ready", 128'(ready), 128'(exp_ready));
    check("dread_valid", 128'(dread_valid), 128'(exp_valid));
    check("dread_data", 128'({dread_data_even, dread_data_odd}), 128'({last_e, last_o}));
    cur = {rae, rao, wae, wao, wde, wdo};
    exp_bus = exp_ready ? cur : held;
    check("t_bus", 128'({t_dread_addr_even, t_dread_addr_odd, t_dwrite_addr_even, t_dwrite_addr_odd,
                         t_dwrite_data_even, t_dwrite_data_odd}), 128'(exp_bus));
    acc = exp_ready && (rq || we_e || we_o);
    ewe = (acc && we_e) ? 2'(1 << tgt_of(int'({wae, 1'b0}))) : 2'b00;
    ewo = (acc && we_o) ? 2'(1 << tgt_of(int'({wao, 1'b1}))) : 2'b00;
    check("t_dwrite_en", 128'({t_dwrite_en_even, t_dwrite_en_odd}), 128'({ewe, ewo}));
    if (acc) begin
      be = int'({rae, 1'b0});
      bo = int'({rao, 1'b1});
      w = 0;
      if (rq) begin
        if (waits_of(tgt_of(be)) > w) w = waits_of(tgt_of(be));
        if (waits_of(tgt_of(bo)) > w) w = waits_of(tgt_of(bo));
      end
      if (we_e && waits_of(tgt_of(int'({wae, 1'b0}))) > w) w = waits_of(tgt_of(int'({wae, 1'b0})));
      if (we_o && waits_of(tgt_of(int'({wao, 1'b1}))) > w) w = waits_of(tgt_of(int'({wao, 1'b1})));
      busy_until = cyc + w + 1;
      held = cur;
      if (rq) q.push_back('{cyc + w + 1, {byte_val(tgt_of(be), be), byte_val(tgt_of(bo), bo)}});
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic rd(input logic [AB-1:0] ae, input logic [AB-1:0] ao);
    step(1'b1, ae, ao, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  // Pulse reset for one clock, checking the asynchronous reset values.
  task automatic do_reset();
    dread_req = 1'b0; dwrite_en_even = 1'b0; dwrite_en_odd = 1'b0;
    reset_n = 1'b0;
    q.delete();
    busy_until = cyc;
    last_e = '0; last_o = '0; held = '0;
    #1;
    check("rst_ready", 128'(ready), 128'(1'b1));
    check("rst_valid", 128'(dread_valid), 128'(1'b0));
    check("rst_data", 128'({dread_data_even, dread_data_odd}), 128'(16'h0000));
    check("rst_wen", 128'({t_dwrite_en_even, t_dwrite_en_odd}), 128'(4'h0));
    @(posedge clk);
    cyc++;
    #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [AB-1:0] rnd_addr();
    if ($urandom_range(0, 2) == 0) return AB'(15'h0FFE + 15'($urandom_range(0, 3)));
    return AB'($urandom);
  endfunction

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    // zero-wait read on target 1
    rd(15'h1800, 15'h1800); idle(2);
    // two-wait read on target 0
    rd(15'h0080, 15'h0080); idle(4);
    // split-target write on both lanes
    step(1'b0, '0, '0, 1'b1, 1'b1, 15'h0010, 15'h1800, 8'hA5, 8'h5A); idle(3);
    // lanes straddling the target boundary
    rd(15'h0FFF, 15'h1000); idle(4);
    // reset aborts a waiting read, then a fresh read right after release
    rd(15'h0080, 15'h0080);
    do_reset();
    rd(15'h1800, 15'h1800); idle(3);
    // back-to-back zero-wait reads
    for (int i = 0; i < 4; i++) rd(AB'(15'h1800 + i), AB'(15'h1800 + i));
    idle(2);
    // simultaneous read and write
    step(1'b1, 15'h1900, 15'h1901, 1'b1, 1'b0, 15'h0100, '0, 8'h3C, '0); idle(4);
    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                rnd_addr(), rnd_addr(), 8'($urandom), 8'($urandom));
    end
    idle(5);
    check("drain", 128'(q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bank_router.md
BANK_ROUTER -- requirements
Module: bank_router

Interface
REQ-001 SHALL have parameter ADDRBITS, default 15: per-bank word address width; byte address = {addr,lane}, lane 0 even, 1 odd.
REQ-002 SHALL have parameter NTARGETS, default 2: number of targets (2..8).
REQ-003 SHALL have parameter BASE, default {16'h2000,16'h0000}: packed NTARGETS x 16-bit ascending byte bases; entry 0 SHALL be 0.
REQ-004 SHALL have parameter WAITS, default {4'd0,4'd2}: packed NTARGETS x 4-bit wait-state count per target.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 dread_addr_even, dread_addr_odd  input  ADDRBITS each  CPU read addresses.
REQ-008 dread_req  input  1  CPU read request.
REQ-009 dwrite_addr_even, dwrite_addr_odd  input  ADDRBITS each  CPU write addresses.
REQ-010 dwrite_data_even, dwrite_data_odd  input  8 each  CPU write data.
REQ-011 dwrite_en_even, dwrite_en_odd  input  1 each  CPU byte write enables.
REQ-012 ready  output  1  router accepts a new access this cycle.
REQ-013 dread_data_even, dread_data_odd  output  8 each  read data to CPU.
REQ-014 dread_valid  output  1  read data valid, one-cycle pulse.
REQ-015 t_dread_addr_even/odd, t_dwrite_addr_even/odd  output  ADDRBITS each  shared target address buses.
REQ-016 t_dwrite_data_even/odd  output  8 each  shared target write data.
REQ-017 t_dwrite_en_even, t_dwrite_en_odd  output  NTARGETS each  one-hot per-target write enables.
REQ-018 t_dread_data_even, t_dread_data_odd  input  8*NTARGETS each  per-target read data, target i at [8i+7:8i].

Function
REQ-019 Each lane SHALL decode independently: target = highest i with byte address >= BASE[i].
REQ-020 Access SHALL be accepted when ready=1 and (dread_req or any dwrite_en); otherwise inputs ignored.
REQ-021 States SHALL be IDLE (ready=1) and WAIT (ready=0).
REQ-022 On acceptance, W = max WAITS over targets of all active lanes (both read lanes if dread_req; each enabled write lane).
REQ-023 W=0: stay IDLE; W>0: go WAIT, counter loaded W-1, decrement each cycle, return IDLE next edge after counter 0.
REQ-024 Writes SHALL assert t_dwrite_en combinationally in acceptance cycle only, one-hot to decoded target; all-zero otherwise.
REQ-025 Read lane targets SHALL be registered on acceptance; dread_valid SHALL pulse at cycle W+1 after acceptance, dread_data muxed from registered targets that cycle.
REQ-026 dread_data SHALL hold last muxed value when dread_valid=0.
REQ-027 Target address/write-data buses SHALL pass CPU inputs in IDLE and held registered copies of accepted values in WAIT.
REQ-028 Read and write in same cycle SHALL both be accepted; single W covers both.
REQ-029 Back-to-back zero-wait reads SHALL sustain one read per cycle, valid pipelined one cycle behind.
REQ-030 Odd and even lanes on different targets SHALL be legal; each lane returns its own target's data.

Reset
REQ-031 reset_n low SHALL asynchronously force IDLE, counter 0, ready=1, dread_valid=0, t_dwrite_en=0, dread_data=0, held registers 0.
REQ-032 Reset during WAIT SHALL abort access with no dread_valid pulse after release.
REQ-033 First access SHALL be acceptable in first clock after reset_n rises.

Verification (defaults)
REQ-034 Read even=0x1800 (byte 0x3000), req=1 -> ready stays 1, dread_valid next cycle, data from target 1.
REQ-035 Read even=0x0080 (byte 0x0100) -> ready low 2 cycles, dread_valid at cycle 3, data from target 0.
REQ-036 Write even 0x0010 data 0xA5 + odd 0x1800 data 0x5A -> t_dwrite_en_even=01, odd=10 in same cycle, ready low 2 cycles.
REQ-037 Read even=0x0FFF, odd=0x1000 -> dread_data_even from target 0 byte 0x1FFE, odd from target 1 byte 0x2001, valid at cycle 3.
REQ-038 reset_n low one cycle after 0x0080 read accepted -> no dread_valid, ready=1 after release; subsequent 0x1800 read valid next cycle.
REQ-039 Four consecutive reads 0x1800..0x1803 -> four consecutive dread_valid pulses, ready constant 1.
